// File: rtl/matmul5_seq.sv
// Sequential NxN matrix multiplier B = A*X (W-bit wrapping arithmetic), streamed in/out
// over valid/ready, using a single shared multiply-accumulate unit.
module matmul5_seq #(
  parameter int N = 5,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int CW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_X,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] oidx_q, oidx_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] k_q, k_d;
  logic [W-1:0]  acc_q, acc_d;

  logic [W-1:0]  a_q [NN];
  logic [W-1:0]  x_q [NN];
  logic [W-1:0]  res_q [NN];

  logic          a_we, x_we, res_we;
  logic          in_fire, out_fire;
  logic [IW-1:0] a_idx, x_idx, res_idx;
  logic [W-1:0]  prod, sum;

  // Ready/valid derive from registered state only; reset masks ready while held.
  assign in_ready  = ((state_q == LOAD_A) || (state_q == LOAD_X)) && !rst;
  assign out_valid = (state_q == OUTPUT);
  assign out_last  = (state_q == OUTPUT) && (oidx_q == LAST_IDX);
  assign out_data  = (state_q == OUTPUT) ? res_q[oidx_q] : '0;
  assign busy      = !((state_q == LOAD_A) && (idx_q == '0));

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign a_idx   = IW'(r_q) * IW'(N) + IW'(k_q);
  assign x_idx   = IW'(k_q) * IW'(N) + IW'(c_q);
  assign res_idx = IW'(r_q) * IW'(N) + IW'(c_q);

  // Low W bits of the product are identical for signed and unsigned operands.
  assign prod = a_q[a_idx] * x_q[x_idx];
  assign sum  = ((k_q == '0) ? '0 : acc_q) + prod;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    oidx_d  = oidx_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    acc_d   = acc_q;
    a_we    = 1'b0;
    x_we    = 1'b0;
    res_we  = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (in_fire) begin
          a_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD_X;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (in_fire) begin
          x_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = COMPUTE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        acc_d = sum;
        if (k_q == LAST_CNT) begin
          res_we = !rst;
          k_d    = '0;
          if (c_q == LAST_CNT) begin
            c_d = '0;
            if (r_q == LAST_CNT) begin
              r_d     = '0;
              state_d = OUTPUT;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (out_fire) begin
          if (oidx_q == LAST_IDX) begin
            oidx_d  = '0;
            state_d = LOAD_A;
          end else begin
            oidx_d = oidx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      oidx_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  // Operand and result storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (a_we) a_q[idx_q] <= in_data;
    if (x_we) x_q[idx_q] <= in_data;
    if (res_we) res_q[res_idx] <= sum;
  end

endmodule

// File: tb/tb_matmul5_seq.sv
// Self-checking bench for matmul5_seq: directed and random frames against a plain
// matrix-product reference model, with input gaps, output backpressure and resets.
module tb_matmul5_seq;

  localparam int N  = 5;
  localparam int NN = N * N;
  localparam int W  = 32;

  typedef logic [W-1:0] mat_t [NN];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  mat_t ma, mx, mexp;

  always #5 clk = ~clk;

  matmul5_seq #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: textbook row-by-column product, wrapped to W bits.
  function automatic void model(input mat_t a, input mat_t x, output mat_t b);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + a[r*N+k] * x[k*N+c];
        b[r*N+c] = s;
      end
  endfunction

  task automatic send_operands(input bit gaps);
    int  i, guard;
    bit  fired;
    i = 0;
    guard = 0;
    while (i < 2*NN && guard < 5000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = (i < NN) ? ma[i] : mx[i-NN];
      fired    = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (fired) i++;
    end
    in_valid = 1'b0;
    checks++;
    if (i != 2*NN) begin
      failures++;
      $display("FAIL load_timeout: accepted=%0d required=%0d", i, 2*NN);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_drop_after_load: in_ready=%b required=0", in_ready);
    end
  endtask

  // Enters in the first cycle after the last operand was accepted.
  task automatic wait_first(input bit junk);
    int cyc;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 400) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (cyc != N*N*N + 1) begin
      failures++;
      $display("FAIL latency: first out_valid cycle=%0d required=%0d", cyc, N*N*N + 1);
    end
  endtask

  task automatic collect(input bit bp);
    int           j, guard;
    bit           held;
    logic [W-1:0] hold_d;
    logic         hold_l;
    j = 0;
    guard = 0;
    held = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    while (j < NN && guard < 400) begin
      out_ready = bp ? ((guard % 4 == 0) || (guard % 4 == 3)) : 1'b1;
      if (held) begin
        checks++;
        if (out_data !== hold_d || out_last !== hold_l) begin
          failures++;
          $display("FAIL stall_hold[%0d]: data=%h last=%b required data=%h last=%b",
                   j, out_data, out_last, hold_d, hold_l);
        end
      end
      held = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL out_valid[%0d]: got=%b required=1", j, out_valid);
      end else if (out_ready) begin
        checks += 2;
        if (out_data !== mexp[j]) begin
          failures++;
          $display("FAIL out_data[%0d]: got=%h required=%h", j, out_data, mexp[j]);
        end
        if (out_last !== (j == NN-1)) begin
          failures++;
          $display("FAIL out_last[%0d]: got=%b required=%b", j, out_last, (j == NN-1));
        end
        j++;
      end else begin
        held   = 1'b1;
        hold_d = out_data;
        hold_l = out_last;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    checks += 3;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_end_valid: out_valid=%b required=0", out_valid);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL frame_end_busy: busy=%b required=0", busy);
    end
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL frame_end_ready: in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic run_frame(input bit gaps, input bit bp, input bit junk);
    model(ma, mx, mexp);
    send_operands(gaps);
    wait_first(junk);
    collect(bp);
  endtask

  task automatic set_identity_a();
    for (int i = 0; i < NN; i++) ma[i] = (i / N == i % N) ? 32'd1 : 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got=%b required=0", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got=%b required=0", out_valid); end
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got=%b required=0", out_last); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got=%h required=0", out_data); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%b required=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got=%b required=1", in_ready); end
    out_ready = 1'b1;
  endtask

  task automatic test_identity();
    set_identity_a();
    for (int i = 0; i < NN; i++) mx[i] = 32'(i + 1);
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_scaled();
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i / N == i % N) ? 32'd2 : 32'd0;
      mx[i] = 32'd3;
    end
    run_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NN; i++) begin
      ma[i] = 32'd1;
      mx[i] = 32'd1;
    end
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_signed_wrap();
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i / N == i % N) ? 32'hFFFF_FFFF : 32'd0;
      mx[i] = (i / N == i % N) ? 32'd1 : 32'd0;
    end
    run_frame(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NN; i++) begin ma[i] = '0; mx[i] = '0; end
    ma[0] = 32'h0001_0000;
    mx[0] = 32'h0001_0000;
    run_frame(1'b0, 1'b0, 1'b0);
    ma[0] = 32'h7FFF_FFFF;
    mx[0] = 32'd2;
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NN; i++) begin
        ma[i] = $urandom;
        mx[i] = (f == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
      end
      run_frame(1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NN; i++) begin ma[i] = $urandom; mx[i] = $urandom; end
    send_operands(1'b0);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got=%b required=0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got=%b required=0", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready: got=%b required=0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_release_ready: got=%b required=1", in_ready); end
    set_identity_a();
    for (int i = 0; i < NN; i++) mx[i] = $urandom;
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_round_trip();
    int bm [NN];
    int xs [NN];
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i % N >= i / N) ? 32'd1 : 32'd0;
      bm[i] = (i / N == i % N) ? 5 : 0;
    end
    // Stand-in for the inverse block: back-substitution of the unit upper-triangular system.
    for (int c = 0; c < N; c++)
      for (int r = N-1; r >= 0; r--) begin
        int s;
        s = bm[r*N+c];
        for (int j = r+1; j < N; j++) s -= int'(ma[r*N+j]) * xs[j*N+c];
        xs[r*N+c] = s;
      end
    for (int i = 0; i < NN; i++) mx[i] = 32'(xs[i]);
    run_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NN; i++) begin
      checks++;
      if (mexp[i] !== 32'(bm[i])) begin
        failures++;
        $display("FAIL round_trip_ref[%0d]: got=%h required=%h", i, mexp[i], 32'(bm[i]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scaled();
    test_signed_wrap();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
